// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling, framing-error
// detection and break hold-off until the line returns high.
module uart_rx #(
  parameter int unsigned CLK_RATE         = 50000000,
  parameter int unsigned SERIAL_BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       new_data_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CLK_PER_BIT = CLK_RATE / SERIAL_BAUD_RATE;
  localparam int unsigned HALF        = CLK_PER_BIT / 2;
  localparam int unsigned CtrW        = $clog2(CLK_PER_BIT);

  localparam logic [CtrW-1:0] CtrHalf = CtrW'(HALF - 1);
  localparam logic [CtrW-1:0] CtrLast = CtrW'(CLK_PER_BIT - 1);
  localparam logic [CtrW-1:0] CtrOne  = CtrW'(1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CtrW-1:0] ctr_q, ctr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            new_data_q, new_data_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_meta_q, rx_s_q;

  // Synchroniser resets to the idle level so no false start follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ctr_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q + CtrOne;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          ctr_d   = '0;
        end
      end
      StStart: begin
        if (ctr_q == CtrHalf) begin
          ctr_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = '0;
          end
        end
      end
      StData: begin
        if (ctr_q == CtrLast) begin
          ctr_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (ctr_q == CtrLast) begin
          ctr_d = '0;
          if (rx_s_q) begin
            data_d     = shift_q;
            new_data_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        if (rx_s_q) begin
          state_d = StIdle;
          ctr_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        ctr_d   = '0;
      end
    endcase
  end

  assign data_o      = data_q;
  assign new_data_o  = new_data_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed scenarios plus randomised
// frame streams checked against an event-level timing model.
module tb_uart_rx;

  localparam int Cpb = 16;
  // Fall on the line to the new_data/frame_err pulse: 9.5 bits + sync + register.
  localparam int Lat = Cpb * 9 + Cpb / 2 + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       new_data, frame_err, busy;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  typedef struct {
    int         kind;  // 0: new_data, 1: frame_err
    int         at;
    logic [7:0] d;
  } ev_t;

  ev_t ev_q[$];
  ev_t exp_q[$];
  logic prev_nd = 1'b0;
  logic prev_fe = 1'b0;

  uart_rx #(
    .CLK_RATE        (1600),
    .SERIAL_BAUD_RATE(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx),
    .data_o     (data),
    .new_data_o (new_data),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse-shape monitor and event recorder.
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if ((new_data && frame_err) || (new_data && prev_nd) || (frame_err && prev_fe)) begin
        miscompares++;
        $display("FAIL pulse_shape cyc=%0d new_data=%b frame_err=%b prev=%b%b, required single exclusive pulses",
                 cyc, new_data, frame_err, prev_nd, prev_fe);
      end
      if (new_data)  ev_q.push_back('{kind: 0, at: cyc, d: data});
      if (frame_err) ev_q.push_back('{kind: 1, at: cyc, d: data});
    end
    prev_nd = new_data;
    prev_fe = frame_err;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(Cpb);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int fall);
    fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    vectors++;
    if ({data, new_data, frame_err, busy} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_state got data=%h nd=%b fe=%b busy=%b, required 00 0 0 0",
               data, new_data, frame_err, busy);
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_basic;
    int fall;
    ev_q.delete();
    send_frame(8'hA5, 1'b1, fall);
    rx = 1'b1;
    tick(20);
    vectors++;
    if (ev_q.size() != 1 || ev_q[0].kind != 0 || ev_q[0].d !== 8'hA5 ||
        ev_q[0].at < fall + Lat - 1 || ev_q[0].at > fall + Lat + 1) begin
      miscompares++;
      $display("FAIL basic_a5 events=%0d kind=%0d data=%h at=%0d, required 1 new_data A5 at %0d",
               ev_q.size(), ev_q.size() > 0 ? ev_q[0].kind : -1,
               ev_q.size() > 0 ? ev_q[0].d : 8'hxx, ev_q.size() > 0 ? ev_q[0].at : -1,
               fall + Lat);
    end
    vectors++;
    if (data !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_hold got %h, required a5", data);
    end
  endtask

  task automatic test_glitch;
    logic seen_busy;
    seen_busy = 1'b0;
    ev_q.delete();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (busy) seen_busy = 1'b1;
      tick(1);
    end
    vectors++;
    if (!seen_busy || busy !== 1'b0 || ev_q.size() != 0) begin
      miscompares++;
      $display("FAIL glitch seen_busy=%b busy=%b events=%0d, required 1 0 0",
               seen_busy, busy, ev_q.size());
    end
  endtask

  task automatic test_frame_err;
    int fall;
    ev_q.delete();
    send_frame(8'h3C, 1'b0, fall);
    tick(40);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL break_busy got %b, required 1", busy);
    end
    rx = 1'b1;
    tick(5);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL break_release busy got %b, required 0", busy);
    end
    vectors++;
    if (ev_q.size() != 1 || ev_q[0].kind != 1 || ev_q[0].d !== 8'hA5 ||
        ev_q[0].at < fall + Lat - 1 || ev_q[0].at > fall + Lat + 1) begin
      miscompares++;
      $display("FAIL frame_err events=%0d kind=%0d data=%h at=%0d, required 1 frame_err data a5 at %0d",
               ev_q.size(), ev_q.size() > 0 ? ev_q[0].kind : -1,
               ev_q.size() > 0 ? ev_q[0].d : 8'hxx, ev_q.size() > 0 ? ev_q[0].at : -1,
               fall + Lat);
    end
    ev_q.delete();
    send_frame(8'h81, 1'b1, fall);
    rx = 1'b1;
    tick(10);
    vectors++;
    if (ev_q.size() != 1 || ev_q[0].kind != 0 || ev_q[0].d !== 8'h81) begin
      miscompares++;
      $display("FAIL after_break events=%0d data=%h, required 1 new_data 81",
               ev_q.size(), data);
    end
  endtask

  task automatic test_back_to_back;
    int f0, f1;
    ev_q.delete();
    send_frame(8'h00, 1'b1, f0);
    send_frame(8'hFF, 1'b1, f1);
    rx = 1'b1;
    tick(20);
    vectors++;
    if (ev_q.size() != 2 || ev_q[0].kind != 0 || ev_q[1].kind != 0 ||
        ev_q[0].d !== 8'h00 || ev_q[1].d !== 8'hFF ||
        ev_q[1].at - ev_q[0].at < 159 || ev_q[1].at - ev_q[0].at > 161) begin
      miscompares++;
      $display("FAIL back_to_back events=%0d d0=%h d1=%h gap=%0d, required 2 new_data 00,ff gap 160",
               ev_q.size(), ev_q.size() > 0 ? ev_q[0].d : 8'hxx,
               ev_q.size() > 1 ? ev_q[1].d : 8'hxx,
               ev_q.size() > 1 ? ev_q[1].at - ev_q[0].at : -1);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int fall;
    b = 8'h55;
    ev_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    tick(Cpb / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx  = 1'b1;
    tick(200);
    vectors++;
    if (ev_q.size() != 0 || busy !== 1'b0 || data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid events=%0d busy=%b data=%h, required 0 0 00",
               ev_q.size(), busy, data);
    end
    send_frame(8'h12, 1'b1, fall);
    rx = 1'b1;
    tick(10);
    vectors++;
    if (ev_q.size() != 1 || ev_q[0].kind != 0 || ev_q[0].d !== 8'h12) begin
      miscompares++;
      $display("FAIL reset_resume events=%0d data=%h, required 1 new_data 12", ev_q.size(), data);
    end
  endtask

  task automatic test_random(input int n);
    logic [7:0] b, last;
    logic       stop;
    int         fall, gap;
    last = data;
    ev_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = (i % 4 == 0) ? 0 : $urandom_range(0, 20);
      send_frame(b, stop, fall);
      if (stop) begin
        exp_q.push_back('{kind: 0, at: fall + Lat, d: b});
        last = b;
        rx = 1'b1;
        tick(gap);
      end else begin
        exp_q.push_back('{kind: 1, at: fall + Lat, d: last});
        rx = 1'b1;
        tick(4 + gap);
      end
    end
    tick(40);
    vectors++;
    if (ev_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_count got %0d events, required %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      vectors++;
      if (ev_q[i].kind != exp_q[i].kind || ev_q[i].d !== exp_q[i].d ||
          ev_q[i].at < exp_q[i].at - 1 || ev_q[i].at > exp_q[i].at + 1) begin
        miscompares++;
        $display("FAIL random_ev%0d got kind=%0d data=%h at=%0d, required kind=%0d data=%h at=%0d",
                 i, ev_q[i].kind, ev_q[i].d, ev_q[i].at,
                 exp_q[i].kind, exp_q[i].d, exp_q[i].at);
      end
    end
    vectors++;
    if (data !== last) begin
      miscompares++;
      $display("FAIL random_hold got %h, required %h", data, last);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_random(30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLK_RATE, default 50000000, meaning clk frequency in Hz.
REQ-002 The module SHALL have parameter SERIAL_BAUD_RATE, default 9600, meaning line bit rate.
REQ-003 The module SHALL derive localparam CLK_PER_BIT = CLK_RATE/SERIAL_BAUD_RATE (integer divide) and HALF = CLK_PER_BIT/2; CLK_PER_BIT < 4 SHALL be unsupported.
REQ-004 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset: synchronous, active-high.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 data  output  8  last correctly framed byte, held until the next one.
REQ-008 new_data  output  1  single-cycle pulse; data valid in that cycle.
REQ-009 frame_err  output  1  single-cycle pulse on stop-bit error.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; rx_s denotes its output; no other logic SHALL read rx directly.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK.
REQ-013 A bit counter ctr SHALL be wide enough for CLK_PER_BIT-1, clear on every state entry and on every bit sample, and otherwise increment.
REQ-014 IDLE: in the first cycle t0 with rx_s==0, the FSM SHALL move to START.
REQ-015 START: when ctr==HALF-1 (cycle t0+HALF), the FSM SHALL sample rx_s; 1 -> IDLE (glitch, no output); 0 -> DATA with bit index 0.
REQ-016 DATA: when ctr==CLK_PER_BIT-1, the FSM SHALL shift rx_s into the shift register MSB (so bit 0 ends in data[0]); sample k (k=1..8) falls at t0+HALF+k*CLK_PER_BIT; after the 8th sample -> STOP.
REQ-017 STOP: when ctr==CLK_PER_BIT-1 (t0+HALF+9*CLK_PER_BIT), the FSM SHALL sample rx_s; 1 -> load data from shift register, pulse new_data next cycle, go to IDLE.
REQ-018 STOP sample 0 SHALL pulse frame_err next cycle, leave data unchanged, assert no new_data, and go to BREAK.
REQ-019 BREAK SHALL stay until rx_s==1, then go to IDLE; no start detection SHALL occur in BREAK.
REQ-020 new_data and frame_err SHALL never be high in the same cycle and SHALL each be high exactly one cycle per event.
REQ-021 A falling edge occurring in the IDLE cycle right after a stop sample SHALL be accepted (back-to-back bytes with zero idle gap).
REQ-022 Invalid state encodings SHALL return to IDLE.

Reset
REQ-023 With rst high at a clock edge: state=IDLE, ctr=0, shift register=0, data=8'h00, new_data=0, frame_err=0, busy=0, both synchronizer flops=1.
REQ-024 rst asserted mid-byte SHALL abort reception without any new_data or frame_err pulse; reception SHALL resume only on a falling edge seen after reset release.

Verification (bench: CLK_RATE=1600, SERIAL_BAUD_RATE=100, CLK_PER_BIT=16)
REQ-025 Byte 0xA5, stop=1 -> new_data exactly one cycle, data=0xA5, 16*9+8+3 cycles (+/-1) after the rx fall; frame_err stays 0.
REQ-026 rx low for 4 cycles, then high -> busy high briefly, return to IDLE, no new_data, no frame_err.
REQ-027 0x3C with stop=0, then rx held low 40 cycles, then high, then 0x81 -> frame_err one pulse, data stays previous value, busy until rx high, then new_data with data=0x81.
REQ-028 0x00 then 0xFF back-to-back, no idle gap -> two new_data pulses, data=0x00 then 0xFF, about 160 cycles apart.
REQ-029 rst high 1 cycle at DATA bit 4 of 0x55, line then idle -> no pulses, busy=0 after reset, data=0x00; next 0x12 is received correctly.
